// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, IEEE-754 single constants and the normalize->round payload.
//   SIG_W_DEF / EXP_W_DEF / MAN_W_DEF : default significand, exponent and fraction widths
//   EXP_MAX / EXP_BIAS                : all-ones exponent (inf) and single-precision bias
//   s1_t                              : S1->S2 payload (sign, widened exp, G/R/S significand, flags)
package fp_pkg;
    localparam int SIG_W_DEF = 27;
    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam logic [7:0] EXP_MAX = 8'hFF;
    localparam int EXP_BIAS = 127;

    // exp carries one extra bit so a carry-normalized exponent of 0xFF+1 is not lost
    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF:0]   exp;
        logic [SIG_W_DEF-1:0] sig;
        logic                 unf;
        logic                 zero;
    } s1_t;
endpackage

// File: rtl/lzc.sv
// lzc: leading-zero counter.
//   in       : value to scan (MSB first)
//   count    : number of zeros above the first set bit (WIDTH when in is zero)
//   all_zero : in == 0
module lzc #(
    parameter int WIDTH = 27
)(
    input  logic [WIDTH-1:0]         in,
    output logic [$clog2(WIDTH+1)-1:0] count,
    output logic                     all_zero
);
    localparam int CW = $clog2(WIDTH+1);

    // scanning upward lets the highest set bit win
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++)
            if (in[i]) count = CW'(WIDTH - 1 - i);
    end

    assign all_zero = ~|in;
endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: 2-stage normalize (S1) then round-to-nearest-even and pack (S2).
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready             : upstream handshake
//   sig_in, carry_in, exp_in, sign_in : add/sub magnitude (hidden bit MSB, G/R/S LSBs), carry, exponent, sign
//   out_valid/out_ready           : downstream handshake
//   result, overflow, underflow   : packed single-precision value and saturate/flush flags
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int WIDTH = SIG_W_DEF,
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       sig_in,
    input  logic                   carry_in,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic                   sign_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int CW = $clog2(WIDTH+1);

    logic [CW-1:0]        lz;
    logic                 lz_zero;
    s1_t                  n, s1_q;
    logic                 s1_v, s2_v, s1_adv, s2_adv;
    logic                 inc, ovf;
    logic [MAN_W+1:0]     man;
    logic [EXP_W:0]       e2;
    logic [MAN_W-1:0]     frac;
    logic [EXP_W+MAN_W:0] res;

    lzc #(.WIDTH(WIDTH)) u_lzc (.in(sig_in), .count(lz), .all_zero(lz_zero));

    assign s2_adv    = out_ready | ~s2_v;
    assign s1_adv    = s2_adv | ~s1_v;
    assign in_ready  = s1_adv;
    assign out_valid = s2_v;

    // carry: {1,sig} >> 1 with the dropped bit folded into sticky
    always_comb begin
        n.sign = sign_in;
        n.zero = ~carry_in & lz_zero;
        n.unf  = ~carry_in & ~lz_zero & ({1'b0, exp_in} <= (EXP_W+1)'(lz));
        n.exp  = carry_in ? {1'b0, exp_in} + 1'b1 : {1'b0, exp_in} - (EXP_W+1)'(lz);
        n.sig  = carry_in ? {1'b1, sig_in[WIDTH-1:2], sig_in[1] | sig_in[0]} : sig_in << lz;
    end

    // rounding carry out of the hidden bit bumps the exponent and leaves a zero fraction
    always_comb begin
        inc  = s1_q.sig[2] & (s1_q.sig[1] | s1_q.sig[0] | s1_q.sig[3]);
        man  = {1'b0, s1_q.sig[WIDTH-1:3]} + (MAN_W+2)'(inc);
        e2   = s1_q.exp + (EXP_W+1)'(man[MAN_W+1]);
        ovf  = e2 >= (EXP_W+1)'(EXP_MAX);
        frac = man[MAN_W+1] ? '0 : man[MAN_W-1:0];
        res  = s1_q.zero ? '0 :
               s1_q.unf  ? {s1_q.sign, {(EXP_W+MAN_W){1'b0}}} :
               ovf       ? {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                           {s1_q.sign, e2[EXP_W-1:0], frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) s1_q <= n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                result    <= res;
                overflow  <= ovf & ~s1_q.zero & ~s1_q.unf;
                underflow <= s1_q.unf & ~s1_q.zero;
            end
        end
    end
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed vectors with hand-computed expected results for fp_norm_round.
module tb_fp_norm_round;
    logic        clk = 0, rst_n = 1, in_valid = 0, in_ready, carry_in = 0, sign_in = 0;
    logic        out_valid, out_ready = 1, overflow, underflow;
    logic [26:0] sig_in = '0;
    logic [7:0]  exp_in = '0;
    logic [31:0] result;
    int          n_chk = 0, n_bad = 0;

    always #5 clk = ~clk;

    fp_norm_round dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sig_in(sig_in), .carry_in(carry_in), .exp_in(exp_in), .sign_in(sign_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [26:0] s, input logic c, input logic [7:0] e, input logic sg);
        sig_in = s; carry_in = c; exp_in = e; sign_in = sg;
    endtask

    // one item through an idle pipe: accepted, invisible after 1 cycle, visible after 2
    task automatic run_vec(input string tag, input logic [26:0] s, input logic c, input logic [7:0] e,
                           input logic sg, input logic [31:0] r, input logic ov, input logic un);
        @(negedge clk);
        drive(s, c, e, sg);
        in_valid = 1;
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 0;
        drive('1, 1'b1, '1, 1'b1);
        chk({tag, ".lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".res"}, result, r);
        chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
        chk({tag, ".unf"}, 32'(underflow), 32'(un));
    endtask

    initial begin
        #2 rst_n = 0;
        #1;
        chk("rst.vld", 32'(out_valid), 32'd0);
        chk("rst.res", result, 32'd0);
        chk("rst.flags", {30'd0, overflow, underflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1 chk("rst.rdy", 32'(in_ready), 32'd1);

        run_vec("one",      27'h4000000, 0, 8'h7F, 0, 32'h3F800000, 0, 0);
        run_vec("carry",    27'h0000000, 1, 8'h7F, 0, 32'h40000000, 0, 0);
        run_vec("carry_of", 27'h0000000, 1, 8'hFE, 0, 32'h7F800000, 1, 0);
        run_vec("tie_even", 27'h4000004, 0, 8'h7F, 0, 32'h3F800000, 0, 0);
        run_vec("tie_odd",  27'h400000C, 0, 8'h7F, 0, 32'h3F800002, 0, 0);
        run_vec("cancel",   27'h0000008, 0, 8'h7F, 0, 32'h34000000, 0, 0);
        run_vec("unf",      27'h0000008, 0, 8'h10, 0, 32'h00000000, 0, 1);
        run_vec("unf_neg",  27'h0000008, 0, 8'h10, 1, 32'h80000000, 0, 1);
        run_vec("unf_eq",   27'h0000008, 0, 8'h17, 0, 32'h00000000, 0, 1);
        run_vec("min_norm", 27'h0000008, 0, 8'h18, 0, 32'h00800000, 0, 0);
        run_vec("unf_e0",   27'h4000000, 0, 8'h00, 0, 32'h00000000, 0, 1);
        run_vec("zero",     27'h0000000, 0, 8'h7F, 0, 32'h00000000, 0, 0);
        run_vec("zero_neg", 27'h0000000, 0, 8'h7F, 1, 32'h00000000, 0, 0);
        run_vec("rnd_carry",27'h7FFFFFC, 0, 8'h7F, 0, 32'h40000000, 0, 0);
        run_vec("rnd_of",   27'h7FFFFFC, 0, 8'hFE, 1, 32'hFF800000, 1, 0);
        run_vec("sticky",   27'h0000009, 1, 8'h7F, 0, 32'h40000001, 0, 0);
        run_vec("c_tie",    27'h0000008, 1, 8'h7F, 0, 32'h40000000, 0, 0);

        // backpressure: 3 offered with out_ready low, only 2 fit
        @(negedge clk);
        out_ready = 0;
        drive(27'h4000000, 0, 8'h7F, 0);
        in_valid = 1;
        chk("bp.rdyA", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(27'h0000000, 1, 8'h7F, 0);
        chk("bp.rdyB", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(27'h0000008, 0, 8'h7F, 0);
        chk("bp.rdyC0", 32'(in_ready), 32'd0);
        chk("bp.vA0", 32'(out_valid), 32'd1);
        chk("bp.resA0", result, 32'h3F800000);
        @(negedge clk);
        chk("bp.rdyC1", 32'(in_ready), 32'd0);
        chk("bp.resA1", result, 32'h3F800000);
        out_ready = 1;
        #1 chk("bp.rdyC2", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 0;
        chk("bp.vB", 32'(out_valid), 32'd1);
        chk("bp.resB", result, 32'h40000000);
        @(negedge clk);
        chk("bp.vC", 32'(out_valid), 32'd1);
        chk("bp.resC", result, 32'h34000000);
        @(negedge clk);
        chk("bp.empty", 32'(out_valid), 32'd0);

        // reset with two items in flight
        out_ready = 0;
        drive(27'h4000000, 0, 8'h7F, 0);
        in_valid = 1;
        @(negedge clk);
        drive(27'h0000000, 1, 8'h7F, 0);
        @(negedge clk);
        in_valid = 0;
        chk("mr.pre", 32'(out_valid), 32'd1);
        rst_n = 0;
        #1;
        chk("mr.vld", 32'(out_valid), 32'd0);
        chk("mr.res", result, 32'd0);
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mr.stale", 32'(out_valid), 32'd0);
        end
        run_vec("post_rst", 27'h400000C, 0, 8'h7F, 1, 32'hBF800002, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
